dcache_ctrl: RTL
================

# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache controller for the memory (M) stage of the pipelined MIPS core. It sits between the M-stage load/store signals and the word-addressed data memory. It answers hits in the same cycle. On a miss it drives `CacheReady` low, which the hazard unit uses to stall the pipeline while the controller fills a 4-word line or completes a write-through.

## Interface
- `INDEX_W`, 6: line index bits (64 lines); tag width = 28 − `INDEX_W`.
- `CLK` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `lwInM` in 1: load in M stage.
- `swInM` in 1: store in M stage.
- `AddrM` in 32: byte address; bits [1:0] ignored.
- `WriteDataM` in 32: store data.
- `ReadDataM` out 32: load data, valid when `CacheReady`=1 and `lwInM`=1.
- `CacheReady` out 1: 1 means the current M-stage access completes this cycle.
- `mem_addr` out 32: word-aligned memory address.
- `mem_wdata` out 32: memory write data.
- `mem_re` out 1: memory read request.
- `mem_we` out 1: memory write request.
- `mem_rdata` in 32: memory read data, valid with `mem_ack`.
- `mem_ack` in 1: memory completes the current request this cycle.

## Operation
- Address split: offset = `AddrM[3:2]`, index = `AddrM[INDEX_W+3:4]`, tag = `AddrM[31:INDEX_W+4]`.
- Storage per line: valid bit, tag, 4×32 data.
- Hit condition: valid[index] and tag match.
- FSM states:
  - **IDLE**
    - no op: `CacheReady`=1.
    - `lwInM` hit: `ReadDataM` = line word, `CacheReady`=1, stay in IDLE.
    - `lwInM` miss: `CacheReady`=0, counter := 0, go to FILL.
    - `swInM` (hit or miss): `CacheReady`=0, go to WRITE.
    - `lwInM` and `swInM` both high: treated as a store.
  - **FILL**
    - `mem_re`=1, `mem_addr` = {tag, index, counter, 2'b00}.
    - On each `mem_ack`, write `mem_rdata` into line word[counter] and increment the counter.
    - After the ack for word 3: set valid, write the tag, go to DONE.
  - **WRITE**
    - `mem_we`=1, `mem_addr` = {`AddrM[31:2]`, 2'b00}, `mem_wdata` = `WriteDataM`.
    - On `mem_ack`: if the access hits, update the cached word. A miss leaves the cache unchanged (no allocate). Go to DONE.
  - **DONE**
    - `CacheReady`=1 for one cycle. For a load, `ReadDataM` = the filled word.
    - Go to IDLE.
- `mem_re` and `mem_we` are never high together. Both are 0 in IDLE and DONE.
- The hazard unit holds `lwInM`, `swInM`, `AddrM` and `WriteDataM` stable while `CacheReady`=0. The controller does not re-sample them.
- Reset values:
  - state = IDLE, all valid bits = 0, counter = 0.
  - `CacheReady`=1, `mem_re`=0, `mem_we`=0.
  - `ReadDataM`, `mem_addr` and `mem_wdata` = 0.
  - The data and tag arrays need not be cleared.

## Timing
- Load hit: 0 stall cycles. `CacheReady` and `ReadDataM` are combinational from `AddrM` and the arrays.
- Load miss: stall = 4 + Σ(ack wait cycles) + 1 (DONE). With single-cycle `mem_ack` this is 4 FILL cycles, then DONE, so the load retires 5 cycles after entering M.
- Store: 1 or more WRITE cycles, then DONE. With an immediate ack the store retires 2 cycles after entering M.
- A request is held, with address and data stable, until `mem_ack` is sampled high. The next fill word is presented on the following edge.
- The next M-stage access is evaluated in the IDLE cycle after DONE. Back-to-back accesses are supported.
- Reset asserted mid-FILL or mid-WRITE:
  - The FSM returns to IDLE and `mem_re`/`mem_we` drop immediately.
  - The partially filled line stays invalid.
- Line-index aliasing: a fill overwrites the tag and data of the previous line without write-back. This is safe because the cache is write-through.

## Test plan
- **Cold load miss, then hit:**
  - Memory words 0x80..0x8C = 0x11, 0x22, 0x33, 0x44; ack is immediate.
  - lw 0x84: `CacheReady` low for 5 cycles, `ReadDataM`=0x22.
  - lw 0x8C in the next IDLE cycle: `ReadDataM`=0x44 with 0 stall cycles.
- **Store hit write-through:**
  - After the fill above, sw 0x88 data 0xDEAD: `mem_we` is high with `mem_addr`=0x88 and `mem_wdata`=0xDEAD.
  - Memory and cache both hold 0xDEAD.
  - A following lw 0x88 hits and returns 0xDEAD.
- **Store miss no-allocate:**
  - sw 0x400 data 0x5 into an invalid line: memory is updated.
  - A following lw 0x400 misses and refills with 4 memory reads.
- **Conflict eviction:**
  - lw 0x80, then lw 0x80+(16<<`INDEX_W`) (same index, different tag): the second access misses.
  - lw 0x80 again misses and returns the original value.
- **Delayed ack:**
  - Memory acks 3 cycles after each request.
  - A load miss stalls for 4×3+1 = 13 cycles.
  - `mem_addr` is stable across each wait, and words are filled in order 0..3.
- **Reset mid-fill:**
  - Assert `reset` after the 2nd ack of a fill.
  - `mem_re`=0 immediately and `CacheReady`=1.
  - After reset is released, the same load misses again and performs a full 4-word fill.

Source files
------------

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through no-write-allocate data cache controller
// Hits answer combinationally in IDLE; misses fill a 4-word line, stores write through to memory.
module dcache_ctrl #(
   parameter int INDEX_W = 6
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic        lwInM,
   input  logic        swInM,
   input  logic [31:0] AddrM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        CacheReady,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_re,
   output logic        mem_we,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack
);

   localparam int TAG_W = 28 - INDEX_W;
   localparam int LINES = 1 << INDEX_W;

   typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

   state_t state, state_next;
   logic [1:0] cnt;

   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tags [LINES];
   logic [31:0]      data [LINES*4];

   logic [1:0]         off;
   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag_a;
   logic               hit;
   logic               is_load;
   logic [31:0]        line_word;
   logic               unused_addr_bits;

   assign off       = AddrM[3:2];
   assign idx       = AddrM[INDEX_W+3:4];
   assign tag_a     = AddrM[31:INDEX_W+4];
   assign hit       = valid[idx] && (tags[idx] == tag_a);
   assign is_load   = lwInM && !swInM;
   assign line_word = data[{idx, off}];
   // Byte lanes are irrelevant to a word-addressed memory.
   assign unused_addr_bits = ^AddrM[1:0];

   always_comb begin
      state_next = state;
      CacheReady = 1'b1;
      ReadDataM  = '0;
      mem_addr   = '0;
      mem_wdata  = '0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      case (state)
         IDLE: begin
            if (swInM) begin
               CacheReady = 1'b0;
               state_next = WRITE;
            end else if (lwInM) begin
               if (hit) begin
                  ReadDataM = line_word;
               end else begin
                  CacheReady = 1'b0;
                  state_next = FILL;
               end
            end
         end
         FILL: begin
            CacheReady = 1'b0;
            mem_re     = 1'b1;
            mem_addr   = {tag_a, idx, cnt, 2'b00};
            if (mem_ack && cnt == 2'd3) begin
               state_next = DONE;
            end
         end
         WRITE: begin
            CacheReady = 1'b0;
            mem_we     = 1'b1;
            mem_addr   = {AddrM[31:2], 2'b00};
            mem_wdata  = WriteDataM;
            if (mem_ack) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (is_load) begin
               ReadDataM = line_word;
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      // Outputs take their reset values for as long as reset is held.
      if (reset) begin
         CacheReady = 1'b1;
         ReadDataM  = '0;
         mem_addr   = '0;
         mem_wdata  = '0;
         mem_re     = 1'b0;
         mem_we     = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         valid <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && is_load && !hit) begin
            // The line is invalid until all four words have arrived.
            cnt        <= '0;
            valid[idx] <= 1'b0;
         end
         if (state == FILL && mem_ack) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
               valid[idx] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (state == FILL && mem_ack) begin
         data[{idx, cnt}] <= mem_rdata;
         if (cnt == 2'd3) begin
            tags[idx] <= tag_a;
         end
      end
      if (state == WRITE && mem_ack && hit) begin
         data[{idx, off}] <= WriteDataM;
      end
   end

endmodule
